// File: rtl/pool_stream_unit_if.sv
// Valid/ready stream bundle used on both sides of pool_stream_unit.
// The producer drives data/valid through master; the consumer drives ready through slave.
interface pool_stream_unit_if #(
   parameter int unsigned BITWIDTH = 8
);
   logic [BITWIDTH-1:0] data;
   logic                valid;
   logic                ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/pool_stream_unit.sv
// Streaming 1-D max/average pooling over a sliding window, one result every STRIDE samples.
// Define POOL_AVG_EN to build the average path (mode=1); otherwise the result is always max.
module pool_stream_unit #(
   parameter int unsigned BITWIDTH = 8,
   parameter int unsigned WINDOW   = 4,
   parameter int unsigned STRIDE   = 4
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                clr,
   input  logic                mode,
   pool_stream_unit_if.slave   in_stream,
   pool_stream_unit_if.master  out_stream
);

   localparam int unsigned FillW  = $clog2(WINDOW + 1);
   localparam int unsigned PhaseW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
   localparam logic [FillW-1:0]  FillFull  = FillW'(WINDOW);
   localparam logic [FillW-1:0]  FillLast  = FillW'(WINDOW - 1);
   localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(STRIDE - 1);

   if (WINDOW < 2) begin : g_bad_window_len
      $error("pool_stream_unit: WINDOW must be at least 2");
   end
   if (STRIDE < 1 || STRIDE > WINDOW) begin : g_bad_stride
      $error("pool_stream_unit: STRIDE must be in 1..WINDOW");
   end

   logic [BITWIDTH-1:0] buf_q [WINDOW];
   logic [BITWIDTH-1:0] buf_d [WINDOW];
   logic [FillW-1:0]    fill_q, fill_d;
   logic [PhaseW-1:0]   phase_q, phase_d;
   logic                out_valid_q, out_valid_d;
   logic [BITWIDTH-1:0] out_data_q, out_data_d;
   logic                in_ready;
   logic                accept;
   logic                trigger;
   logic [BITWIDTH-1:0] max_val;
   logic [BITWIDTH-1:0] result;

   // A stalled result blocks intake, so nothing is ever dropped or overwritten.
   assign in_ready        = rstn && !clr && (!out_valid_q || out_stream.ready);
   assign in_stream.ready = in_ready;
   assign accept          = in_stream.valid && in_ready;

   assign out_stream.valid = out_valid_q;
   assign out_stream.data  = out_data_q;

   always_comb begin
      buf_d = buf_q;
      if (accept) begin
         buf_d[0] = in_stream.data;
         for (int i = 1; i < int'(WINDOW); i++) begin
            buf_d[i] = buf_q[i-1];
         end
      end
   end

   // buf_d is the window including the incoming sample; only consulted on a trigger.
   always_comb begin
      max_val = buf_d[0];
      for (int i = 1; i < int'(WINDOW); i++) begin
         if (buf_d[i] > max_val) begin
            max_val = buf_d[i];
         end
      end
   end

`ifdef POOL_AVG_EN
   localparam int unsigned LogW = $clog2(WINDOW);
   localparam int unsigned SumW = BITWIDTH + LogW;

   if ((WINDOW & (WINDOW - 1)) != 0) begin : g_bad_window_pow2
      $error("pool_stream_unit: WINDOW must be a power of two with POOL_AVG_EN");
   end

   logic [SumW-1:0] sum;
   logic [SumW-1:0] avg_full;

   always_comb begin
      sum = '0;
      for (int i = 0; i < int'(WINDOW); i++) begin
         sum = sum + SumW'(buf_d[i]);
      end
   end

   assign avg_full = sum >> LogW;
   assign result   = mode ? avg_full[BITWIDTH-1:0] : max_val;
`else
   logic unused_mode;
   assign unused_mode = mode;
   assign result      = max_val;
`endif

   // The fill-completing sample emits first, then every STRIDE-th accepted sample.
   always_comb begin
      fill_d  = fill_q;
      phase_d = phase_q;
      trigger = 1'b0;
      if (clr) begin
         fill_d  = '0;
         phase_d = '0;
      end else if (accept) begin
         if (fill_q == FillLast) begin
            fill_d  = FillFull;
            phase_d = '0;
            trigger = 1'b1;
         end else if (fill_q == FillFull) begin
            if (phase_q == PhaseLast) begin
               phase_d = '0;
               trigger = 1'b1;
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end else begin
            fill_d = fill_q + 1'b1;
         end
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (trigger) begin
         out_valid_d = 1'b1;
         out_data_d  = result;
      end else if (out_valid_q && out_stream.ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         buf_q       <= '{default: '0};
         fill_q      <= '0;
         phase_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         buf_q       <= buf_d;
         fill_q      <= fill_d;
         phase_q     <= phase_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

endmodule

// File: doc/pool_stream_unit.md
# pool_stream_unit

Streaming 1-D pooling unit with a valid/ready handshake on both sides. It consumes one unsigned sample per accepted beat and keeps a sliding window of the last `WINDOW` samples. It emits the max, or optionally the average, of that window every `STRIDE` accepted samples. It replaces the fixed enable-driven pool stage in the feature pipeline, between the convolution output stream and the next layer's input buffer.

## Interface
- `BITWIDTH`, 8: sample and result width, unsigned.
- `WINDOW`, 4: pooling window length in samples, ≥2.
- `STRIDE`, 4: accepted samples between successive outputs once the window is full, 1..`WINDOW`.

- `clk` input 1: single clock, all logic on rising edge.
- `rstn` input 1: reset, synchronous, active-low.
- `clr` input 1: synchronous clear of window state (row boundary).
- `mode` input 1: 0 = max, 1 = average (see Configuration).
- `in_data` input `BITWIDTH`: sample.
- `in_valid` input 1: sample present.
- `in_ready` output 1: unit can accept a sample.
- `out_data` output `BITWIDTH`: pooled result.
- `out_valid` output 1: result present.
- `out_ready` input 1: downstream accepts the result.

## Operation
- A sample is accepted when `in_valid && in_ready`.
- Accepted samples shift into a `WINDOW`-deep register buffer, newest at index 0.
- `fill` counter, 0..`WINDOW`:
  - Increments per accepted sample.
  - Saturates at `WINDOW`.
- `phase` counter, 0..`STRIDE`-1, advances only while `fill == WINDOW`.
- Emission:
  - The accepted sample that brings `fill` to `WINDOW` emits, and sets `phase` to 0.
  - After that, a sample emits when it is accepted with `phase == STRIDE-1`, and `phase` wraps to 0.
  - Otherwise `phase` increments.
- Result is computed over the `WINDOW` samples including the triggering sample.
  - Max: unsigned compare.
  - Average: sum at width `BITWIDTH+$clog2(WINDOW)`, then `>> $clog2(WINDOW)`, floor, truncated to `BITWIDTH`.
- `mode` is sampled on the triggering beat.
- `in_ready = rstn && !clr && (!out_valid || out_ready)`.
  - A sample is therefore never accepted while a result is stalled.
  - No result is ever dropped or overwritten.
- `clr` high:
  - Clears `fill` and `phase`, not the buffer contents. Stale contents are never used, because `fill` gates emission.
  - No sample is accepted in that cycle.
  - A pending `out_valid`/`out_data` is kept until handshaken.
- Output register:
  - `out_valid` sets on a triggering beat.
  - `out_valid` clears when `out_valid && out_ready` and no new trigger occurs in the same cycle.
  - If a trigger coincides with the output handshake, the new result loads and `out_valid` stays 1.

## Timing
- Reset (`rstn` low at an edge):
  - `out_valid`=0, `out_data`=0, `fill`=0, `phase`=0, buffer=0.
  - `in_ready`=0 while `rstn` low.
- Reset mid-window or mid-stall discards all state, including a pending result.
- Latency: `out_valid` rises at the clock edge that accepts the triggering sample. The result is visible in the next cycle.
- Throughput: one sample per cycle with `out_ready` held high.
  - Full rate also holds while a result is pending, because the handshake and the new accept share a cycle.
- `out_data` holds stable while `out_valid && !out_ready`.
- Window arithmetic is single-cycle combinational over the buffer plus the incoming sample. No internal pipeline.

## Configuration
- `POOL_AVG_EN` defined:
  - Average path is built and `mode`=1 selects it.
  - `WINDOW` must be a power of two; elaboration error otherwise.
- `POOL_AVG_EN` undefined:
  - No adder tree.
  - `mode` is ignored and the result is always max.
  - `WINDOW` may be any value ≥2.

## Test plan
- WINDOW=4, STRIDE=4, max, `out_ready`=1; inputs 3,9,1,7,2,2,8,5 → outputs 9 (after 4th sample), 8 (after 8th); no other `out_valid`.
- Same stream, `POOL_AVG_EN`, `mode`=1 → outputs 5 (20>>2), 4 (17>>2).
- WINDOW=4, STRIDE=2, max; inputs 1,2,3,4,5,0 → outputs 4 (after 4th), 5 (after 6th).
- Backpressure: `out_ready`=0 after first result.
  - Required: `in_ready`=0, `out_data` stable at 9, `in_valid` beats not consumed.
  - Release `out_ready` → `in_ready` returns to 1 in that cycle, and the stream resumes with no sample lost.
- `clr` pulse after 2 samples of a window, then 4 new samples 6,1,1,1 → single output 6. `clr` cycle shows `in_ready`=0.
- `rstn` low for 1 cycle with a stalled result pending → `out_valid`=0 and `out_data`=0 next cycle; next window needs 4 fresh samples.
